// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: opcode encodings, MDU state encoding, iteration count.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cpu_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mduState_t;

endpackage

// File: rtl/mdu_addsub.sv
// Combinational add/subtract shared by the Booth step and the restoring trial subtract.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result follows the inputs.
module mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // Select a - b or a + b
  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// Latency: 34 cycles from accepted start to done; divide-by-zero completes in 1 cycle.
// Backpressure: start is accepted only in IDLE; starts while busy are dropped, never queued.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mduState_t        state;
  logic             isDiv;
  logic [WIDTH:0]   accA;     // Booth A, or restoring remainder R
  logic [WIDTH-1:0] regQ;     // multiplier / quotient shift register
  logic             qM1;      // Booth q(-1)
  logic [WIDTH:0]   regM;     // sign-extended multiplicand, or zero-extended |divisor|
  logic [CW-1:0]    count;
  logic             negQuot;
  logic             negRem;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   shiftR;
  logic [WIDTH:0]   addX;
  logic             addSub;
  logic [WIDTH:0]   addRes;
  logic             boothOp;
  logic [WIDTH:0]   boothA;
  logic [WIDTH-1:0] fixHigh;
  logic [WIDTH-1:0] fixLow;

  // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude
  assign absA = operand_a[WIDTH-1] ? (-operand_a) : operand_a;
  assign absB = operand_b[WIDTH-1] ? (-operand_b) : operand_b;

  // Datapath steering for the shared adder: divide trial-subtracts on the shifted remainder
  always_comb begin
    shiftR  = {accA[WIDTH-1:0], regQ[WIDTH-1]};
    addX    = isDiv ? shiftR : accA;
    addSub  = isDiv ? 1'b1 : regQ[0];
    boothOp = regQ[0] ^ qM1;
    boothA  = boothOp ? addRes : accA;
  end

  mdu_addsub #(.W(WIDTH + 1)) uAddSub (
    .a   (addX),
    .b   (regM),
    .sub (addSub),
    .sum (addRes)
  );

  // Final sign correction: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    fixHigh = accA[WIDTH-1:0];
    fixLow  = regQ;
    if (isDiv) begin
      if (negRem)  fixHigh = -accA[WIDTH-1:0];
      if (negQuot) fixLow  = -regQ;
    end
  end

  // Control FSM, iteration counter, shift registers and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      z_high      <= '0;
      z_low       <= '0;
      count       <= '0;
      isDiv       <= 1'b0;
      accA        <= '0;
      regQ        <= '0;
      qM1         <= 1'b0;
      regM        <= '0;
      negQuot     <= 1'b0;
      negRem      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            isDiv   <= op;
            count   <= '0;
            negQuot <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            negRem  <= operand_a[WIDTH-1];
            accA    <= '0;
            qM1     <= 1'b0;
            if (op == OP_DIV && operand_b == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              z_high      <= operand_a;
              z_low       <= '1;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
              if (op == OP_MUL) begin
                regQ <= operand_b;
                regM <= {operand_a[WIDTH-1], operand_a};
              end else begin
                regQ <= absA;
                regM <= {1'b0, absB};
              end
            end
          end
        end

        RUN: begin
          count <= count + 1'b1;
          if (isDiv) begin
            if (!addRes[WIDTH]) begin
              accA <= addRes;
              regQ <= {regQ[WIDTH-2:0], 1'b1};
            end else begin
              accA <= shiftR;
              regQ <= {regQ[WIDTH-2:0], 1'b0};
            end
          end else begin
            accA <= {boothA[WIDTH], boothA[WIDTH:1]};
            regQ <= {boothA[0], regQ[WIDTH-1:1]};
            qM1  <= regQ[0];
          end
          if (count == LAST_ITER) state <= FIX;
        end

        FIX: begin
          z_high <= fixHigh;
          z_low  <= fixLow;
          done   <= 1'b1;
          state  <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Latency: checks the 34-cycle normal and 1-cycle divide-by-zero completion.
// Backpressure: checks that starts while busy are ignored and clear aborts silently.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] z_high;
  logic [31:0] z_low;

  int vecs = 0;
  int errs = 0;
  int lat;
  logic busyBad;
  logic sawDone;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .z_high      (z_high),
    .z_low       (z_low)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a start in the current cycle T and wait for done; lat = cycles after T, -1 on timeout.
  // Operands and op are scrambled every cycle while running; a start is re-pulsed at cycle T+injectAt.
  task automatic doOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                      input int injectAt, output int latency, output logic busyErr);
    latency = -1;
    busyErr = 1'b0;
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (!busy) busyErr = 1'b1;
      if (done) begin
        latency = n;
        break;
      end
      operand_a = $urandom;
      operand_b = $urandom;
      op = $urandom_range(0, 1);
      start = (n == injectAt);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset
    clear = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    check("rst_zh", z_high, 32'h0);
    check("rst_zl", z_low, 32'h0);
    clear = 1'b0;
    tick();

    // MUL 7 x -3
    doOp(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0, lat, busyBad);
    check("mul1_lat", 32'(lat), 32'd34);
    check("mul1_busy", {31'b0, busyBad}, 32'd0);
    check("mul1_zh", z_high, 32'hFFFF_FFFF);
    check("mul1_zl", z_low, 32'hFFFF_FFEB);
    check("mul1_dbz", {31'b0, div_by_zero}, 32'd0);
    tick();
    check("mul1_idle_busy", {31'b0, busy}, 32'd0);
    check("mul1_idle_done", {31'b0, done}, 32'd0);
    check("mul1_hold_zl", z_low, 32'hFFFF_FFEB);

    // MUL most-negative squared, back-to-back in the first IDLE cycle
    doOp(1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, busyBad);
    check("mul2_lat", 32'(lat), 32'd34);
    check("mul2_zh", z_high, 32'h4000_0000);
    check("mul2_zl", z_low, 32'h0000_0000);
    tick();

    // MUL most-positive squared
    doOp(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, lat, busyBad);
    check("mul3_zh", z_high, 32'h3FFF_FFFF);
    check("mul3_zl", z_low, 32'h0000_0001);
    tick();

    // DIV -7 / 2
    doOp(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, lat, busyBad);
    check("div1_lat", 32'(lat), 32'd34);
    check("div1_q", z_low, 32'hFFFF_FFFD);
    check("div1_r", z_high, 32'hFFFF_FFFF);
    check("div1_dbz", {31'b0, div_by_zero}, 32'd0);
    tick();

    // DIV 7 / -2
    doOp(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, lat, busyBad);
    check("div2_q", z_low, 32'hFFFF_FFFD);
    check("div2_r", z_high, 32'h0000_0001);
    check("div2_dbz", {31'b0, div_by_zero}, 32'd0);
    tick();

    // DIV 100 / 7
    doOp(1'b1, 32'd100, 32'd7, 0, lat, busyBad);
    check("div3_q", z_low, 32'd14);
    check("div3_r", z_high, 32'd2);
    tick();

    // DIV overflow case wraps
    doOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busyBad);
    check("div4_lat", 32'(lat), 32'd34);
    check("div4_q", z_low, 32'h8000_0000);
    check("div4_r", z_high, 32'h0000_0000);
    check("div4_dbz", {31'b0, div_by_zero}, 32'd0);
    tick();

    // DIV by zero
    doOp(1'b1, 32'd5, 32'd0, 0, lat, busyBad);
    check("dbz_lat", 32'(lat), 32'd1);
    check("dbz_busy", {31'b0, busyBad}, 32'd0);
    check("dbz_flag", {31'b0, div_by_zero}, 32'd1);
    check("dbz_zl", z_low, 32'hFFFF_FFFF);
    check("dbz_zh", z_high, 32'd5);
    tick();
    check("dbz_idle_busy", {31'b0, busy}, 32'd0);
    check("dbz_sticky", {31'b0, div_by_zero}, 32'd1);

    // MUL -5 x 6 clears the sticky flag; a start pulsed at T+5 is ignored
    doOp(1'b0, 32'hFFFF_FFFB, 32'd6, 5, lat, busyBad);
    check("mul4_lat", 32'(lat), 32'd34);
    check("mul4_busy", {31'b0, busyBad}, 32'd0);
    check("mul4_zh", z_high, 32'hFFFF_FFFF);
    check("mul4_zl", z_low, 32'hFFFF_FFE2);
    check("mul4_dbz", {31'b0, div_by_zero}, 32'd0);
    tick();
    check("mul4_no_requeue", {31'b0, busy}, 32'd0);

    // Abort: clear at T+10 of a running MUL
    op = 1'b0;
    operand_a = 32'd9;
    operand_b = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_zh", z_high, 32'h0);
    check("abort_zl", z_low, 32'h0);
    sawDone = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy) sawDone = 1'b1;
      tick();
    end
    check("abort_no_done", {31'b0, sawDone}, 32'd0);

    // clear wins over a simultaneous start
    op = 1'b0;
    operand_a = 32'd3;
    operand_b = 32'd4;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("clr_start_busy", {31'b0, busy}, 32'd0);

    // Normal op after abort still works
    doOp(1'b0, 32'd3, 32'd4, 0, lat, busyBad);
    check("mul5_lat", 32'(lat), 32'd34);
    check("mul5_zl", z_low, 32'd12);
    check("mul5_zh", z_high, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle signed multiply/divide unit in the CPU datapath. It takes operand A from the Y register and operand B from the bus output. It produces the 64-bit result pair that drives the bus-mux Z High and Z Low inputs, which the control sequencer later routes to HI/LO. Control handshake: a `start` pulse, a `busy` level and a one-cycle `done` pulse.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH (only 32 is verified).
- clock  in  1  rising-edge clock
- clear  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only in IDLE
- op  in  1  0 = MUL, 1 = DIV
- operand_a  in  WIDTH  Y register; multiplicand / dividend
- operand_b  in  WIDTH  bus value; multiplier / divisor
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; results valid
- div_by_zero  out  1  sticky flag for the last completed op
- z_high  out  WIDTH  product[63:32] / remainder
- z_low  out  WIDTH  product[31:0] / quotient

## Operation
- Reset values (synchronous `clear`):
  - state = IDLE.
  - busy, done and div_by_zero = 0.
  - z_high and z_low = 0.
- Operand capture:
  - op, operand_a and operand_b are sampled on the edge where start=1 in IDLE.
  - Later input changes have no effect.
  - start in RUN, FIX or DONE is ignored. Nothing is queued.
- States:
  - IDLE → RUN on start. Exception: DIV with operand_b == 0 goes IDLE → DONE.
  - RUN: runs exactly WIDTH iterations, tracked by a count register 0..WIDTH-1, then goes to FIX.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- MUL (radix-2 Booth, signed):
  - Registers: A = 0, Q = multiplier, q₋₁ = 0, M = multiplicand.
  - Each iteration examines {Q[0], q₋₁}:
    - 01: A += M.
    - 10: A -= M.
    - 00 / 11: no operation.
  - Then arithmetic-shift {A, Q, q₋₁} right by 1.
  - A uses WIDTH+1 bits so that M = −2³¹ does not overflow.
  - FIX: z_high = A[31:0], z_low = Q.
- DIV (signed, restoring, on magnitudes):
  - Take |dividend| and |divisor| as WIDTH-bit unsigned values; |0x80000000| = 0x80000000.
  - Remainder register is WIDTH+1 bits.
  - Each iteration:
    - Shift {R, Q} left by 1.
    - Compute R − D. If the result is non-negative, keep it and set Q[0] = 1; otherwise restore R and set Q[0] = 0.
  - FIX sign rules:
    - Quotient is negated if the operand signs differ (truncation toward zero).
    - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF wraps: quotient 0x80000000, remainder 0. No flag is raised.
- Divide by zero:
  - div_by_zero = 1.
  - z_low = 0xFFFFFFFF, z_high = dividend.
- div_by_zero is cleared at each start acceptance that is not a divide-by-zero.
- z_high and z_low are loaded only on the edge entering DONE. They hold that value until the next completion or `clear`.

## Timing
- Let T be the cycle in which start is sampled high in IDLE.
- Normal op (MUL or DIV):
  - RUN occupies cycles T+1 … T+32.
  - FIX occupies cycle T+34 − 1 = T+33.
  - done=1 in cycle T+34, with z_high and z_low already valid in that cycle.
  - IDLE at T+35. Latency is 34 cycles.
- Divide by zero: done=1 and results valid in cycle T+1; IDLE at T+2.
- busy is high from T+1 through the done cycle inclusive.
- A new start is accepted no earlier than the first IDLE cycle after done.
- clear has priority over every other event, including a start in the same cycle.
  - clear in any state returns the unit to IDLE with outputs zeroed on the next edge.
  - An aborted op produces no done pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package cpu_pkg holds:
  - Constants OP_MUL = 1'b0 and OP_DIV = 1'b1.
  - The state enum (IDLE, RUN, FIX, DONE).
  - MDU_ITER = 32.
- One sub-module, mdu_addsub, is natural:
  - Combinational WIDTH+1-bit add/subtract, selected by a sub input.
  - Shared by the Booth add/subtract step and the restoring trial subtract.
- The top module holds the FSM, counter, shift registers and FIX logic.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → done at T+34; z_high = 0xFFFFFFFF, z_low = 0xFFFFFFEB; busy high T+1…T+34.
- MUL 0x80000000 × 0x80000000 → z_high = 0x40000000, z_low = 0x00000000; separately, 0x7FFFFFFF × 0x7FFFFFFF → z_high = 0x3FFFFFFF, z_low = 0x00000001.
- DIV −7 / 2 → z_low = 0xFFFFFFFD, z_high = 0xFFFFFFFF; separately, 7 / −2 → z_low = 0xFFFFFFFD, z_high = 0x00000001; div_by_zero = 0 in both.
- DIV 0x80000000 / 0xFFFFFFFF → z_low = 0x80000000, z_high = 0, done at T+34; then DIV 5 / 0 → done at T+1, div_by_zero = 1, z_low = 0xFFFFFFFF, z_high = 5.
- Sequence:
  - Start a MUL.
  - At T+5, pulse start with different operands → ignored; the original result appears at T+34.
  - At T+10 of a second op, assert clear → next cycle busy = 0, z_high = z_low = 0, and no done pulse follows.
- Back-to-back ops: second start issued in the first IDLE cycle after done → accepted, with correct second result 34 cycles later. Operands changed during RUN do not alter either result.
